dds_chirp_ctrl: RTL and testbench
=================================

# dds_chirp_ctrl

Control-side transmitter for the DDS chirp generator, clocked in the 48 MHz domain. Holds chirp parameters written by the register interface and delivers them across the clock boundary with a 4-phase REQ/ACK bundled-data handshake. Generates the `start` gate that runs one chirp per trigger. Guarantees that parameters never change while a chirp is running or while the receiver may be sampling them.

## Interface
Parameters:
- `GAP_CYCLES`, 4: minimum `start` low time after a chirp, in clk_48 cycles; legal range ≥ 2.
- `TIMEOUT_CYCLES`, 1024: REQ-high timeout in clk_48 cycles. Used only with `DDS_CHIRP_CTRL_TIMEOUT_EN`.

Ports:
- `clk_48` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `cfg_wr` in 1: one-cycle strobe that loads the four `cfg_*` fields.
- `cfg_freq` in 48: start phase increment.
- `cfg_delta_freq` in 48: phase-increment step.
- `cfg_delta_rate` in 32: step timer reload value.
- `cfg_len` in 32: chirp length, in clk_48 cycles.
- `trig` in 1: one-cycle chirp request.
- `REQ` out 1: handshake request to the DDS domain.
- `ACK` in 1: handshake acknowledge, already synchronised into clk_48 by the receiver.
- `DDS_freq` out 48: bundled data.
- `DDS_delta_freq` out 48: bundled data.
- `DDS_delta_rate` out 32: bundled data.
- `start` out 1: chirp gate to the DDS.
- `busy` out 1: high in any state other than IDLE.
- `cfg_loaded` out 1: the receiver holds a complete configuration.
- `trig_drop` out 1: one-cycle pulse when a `trig` is discarded.
- `err_timeout` out 1: sticky timeout flag, cleared only by reset.

## Operation
- All outputs reset to 0. FSM resets to IDLE.
- One-deep pending config register, with a `pend` flag.
  - `cfg_wr` in any state writes the pending register and sets `pend`.
  - A later write overwrites it (last-write-wins).
- FSM states: IDLE, SETUP, XFER_REQ, XFER_REL, CHIRP, GAP.
- IDLE:
  - If `pend` and `ACK==0`: copy pending into `DDS_*`, clear `pend`, clear `cfg_loaded`, go to SETUP.
  - Otherwise, on `trig` with `cfg_loaded==1` and `cfg_len!=0`: go to CHIRP.
  - Otherwise `trig` pulses `trig_drop`.
- SETUP: one cycle with data stable and REQ low. Then go to XFER_REQ with REQ=1.
- XFER_REQ: hold REQ=1. When `ACK==1`, drop REQ and go to XFER_REL.
- XFER_REL: when `ACK==0`, set `cfg_loaded` and go to IDLE.
- `DDS_*` are frozen from SETUP until XFER_REL exits. The receiver samples them throughout that window.
- CHIRP:
  - `start=1` for exactly `cfg_len` cycles. The 32-bit down-counter is loaded on entry.
  - Then `start=0` and go to GAP.
- GAP: wait `GAP_CYCLES` cycles, then go to IDLE. This gives the DDS rising-edge detector a clean low.
- `trig` in any non-IDLE state: discarded, `trig_drop` pulses.
- A `cfg_wr` during CHIRP or GAP stays pending. The transfer starts only after returning to IDLE, so a running chirp is never retuned.
- Simultaneous `pend` and `trig` in IDLE: the transfer wins and `trig_drop` pulses.
- Reset mid-handshake: REQ drops asynchronously. After reset, IDLE will not launch a transfer until `ACK==0`.

## Timing
- `cfg_wr` at cycle N in IDLE (empty pend):
  - `pend` set at N+1.
  - `DDS_*` valid, state SETUP at N+2.
  - REQ=1 at N+3.
- `ACK==1` first sampled at cycle M: REQ=0 at M+1.
- `ACK==0` first sampled at cycle K in XFER_REL: `cfg_loaded=1` and `busy=0` at K+1.
- `trig` at cycle T in IDLE: `start=1` for cycles T+1 … T+`cfg_len`.
  - `start=0` at T+`cfg_len`+1.
  - `busy=0` at T+`cfg_len`+`GAP_CYCLES`+1.
- `trig_drop`: asserted for the cycle after the discarded `trig`.
- Counters: `cfg_len` counter is 32-bit unsigned; `GAP_CYCLES` counter is sized `$clog2(GAP_CYCLES+1)`. No wrap is reachable.

## Configuration
- `DDS_CHIRP_CTRL_TIMEOUT_EN` defined:
  - A cycle counter runs in XFER_REQ.
  - After `TIMEOUT_CYCLES` cycles without ACK: drop REQ, set `err_timeout`, go to XFER_REL.
  - `cfg_loaded` stays 0 and `pend` is not restored.
- Not defined: XFER_REQ waits indefinitely and `err_timeout` is tied to 0.

## Structure
- `dds_chirp_pkg` holds:
  - width constants (48, 48, 32, 32);
  - the `dds_chirp_cfg_t` packed struct (freq, delta_freq, delta_rate, len);
  - the FSM state enum.
- Flat single module; no sub-module is warranted.
- Pending and active configurations are both of type `dds_chirp_cfg_t`.

## Test plan
- Transfer with ACK echoed 6 cycles after REQ rise:
  - `cfg_wr` with freq=48'h0000_2800_0000 → REQ high exactly 3 cycles later.
  - `DDS_freq` stable until ACK falls; `cfg_loaded=1` one cycle after ACK low.
- Chirp: `cfg_len`=100, `trig` → `start` high exactly 100 cycles, then low ≥4 cycles. A `trig` inside that window gives `trig_drop=1` and no second chirp.
- `cfg_wr` during CHIRP → `DDS_*` unchanged until `start` falls and GAP ends, then the handshake runs.
- Two `cfg_wr` during one handshake → only the second value is transferred afterwards.
- Timeout (macro on, `TIMEOUT_CYCLES`=16, ACK held 0):
  - REQ drops after 16 cycles.
  - `err_timeout` stays 1.
  - `cfg_loaded` stays 0.
- Async reset while REQ=1 with ACK still high for 3 cycles after release:
  - All outputs read 0.
  - A new `cfg_wr` is not requested until ACK is low.

Source files
------------

// File: rtl/dds_chirp_pkg.sv
// dds_chirp_pkg: shared types for the DDS chirp control path.
//   - field widths of the chirp configuration
//   - dds_chirp_cfg_t: one complete chirp configuration (freq, delta_freq, delta_rate, len)
//   - dds_chirp_state_e: transmitter FSM states
package dds_chirp_pkg;

    localparam int unsigned FreqW      = 48;
    localparam int unsigned DeltaFreqW = 48;
    localparam int unsigned DeltaRateW = 32;
    localparam int unsigned LenW       = 32;

    typedef struct packed {
        logic [FreqW-1:0]      freq;
        logic [DeltaFreqW-1:0] delta_freq;
        logic [DeltaRateW-1:0] delta_rate;
        logic [LenW-1:0]       len;
    } dds_chirp_cfg_t;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StXferReq,
        StXferRel,
        StChirp,
        StGap
    } dds_chirp_state_e;

endpackage

// File: rtl/dds_chirp_ctrl.sv
// dds_chirp_ctrl: control-side transmitter for the DDS chirp generator (clk_48 domain).
// Buffers one pending chirp configuration, ships it to the DDS domain with a 4-phase
// REQ/ACK bundled-data handshake, and generates one `start` gate per accepted trigger.
// The bundled data (DDS_*) only changes in IDLE, never during a chirp or handshake.
//
// Ports:
//   clk_48, rst_n           clock, asynchronous active-low reset
//   cfg_wr, cfg_*           one-cycle write of the pending configuration
//   trig                    one-cycle chirp request
//   REQ / ACK               handshake (ACK already synchronised into clk_48)
//   DDS_freq/_delta_freq/_delta_rate   bundled data to the DDS domain
//   start                   chirp gate, high for cfg len cycles
//   busy                    FSM not in IDLE
//   cfg_loaded              receiver holds a complete configuration
//   trig_drop               one-cycle pulse for every discarded trig
//   err_timeout             sticky handshake timeout flag
//
// Build option: define DDS_CHIRP_CTRL_TIMEOUT_EN to abandon a handshake whose REQ has been
// high for TIMEOUT_CYCLES cycles without ACK; otherwise XFER_REQ waits indefinitely.
module dds_chirp_ctrl
    import dds_chirp_pkg::*;
#(
    parameter int unsigned GAP_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_48,
    input  logic                  rst_n,
    input  logic                  cfg_wr,
    input  logic [FreqW-1:0]      cfg_freq,
    input  logic [DeltaFreqW-1:0] cfg_delta_freq,
    input  logic [DeltaRateW-1:0] cfg_delta_rate,
    input  logic [LenW-1:0]       cfg_len,
    input  logic                  trig,
    output logic                  REQ,
    input  logic                  ACK,
    output logic [FreqW-1:0]      DDS_freq,
    output logic [DeltaFreqW-1:0] DDS_delta_freq,
    output logic [DeltaRateW-1:0] DDS_delta_rate,
    output logic                  start,
    output logic                  busy,
    output logic                  cfg_loaded,
    output logic                  trig_drop,
    output logic                  err_timeout
);

    localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);

    dds_chirp_state_e state_q, state_d;
    dds_chirp_cfg_t   cfg_pend_q, cfg_act_q;
    logic             pend_q;
    logic             launch;
    logic             req_q, req_d;
    logic             start_q, start_d;
    logic             cfg_loaded_q, cfg_loaded_d;
    logic             trig_drop_q, trig_drop_d;
    logic [LenW-1:0]  len_cnt_q, len_cnt_d;
    logic [GapW-1:0]  gap_cnt_q, gap_cnt_d;
    logic             xfer_fail;

`ifdef DDS_CHIRP_CTRL_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            tmo_fail_q, tmo_fail_d;
    logic            err_q, err_d;
    assign xfer_fail   = tmo_fail_q;
    assign err_timeout = err_q;
`else
    assign xfer_fail   = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        launch       = 1'b0;
        cfg_loaded_d = cfg_loaded_q;
        // Every trig is dropped unless IDLE actually starts a chirp with it.
        trig_drop_d  = trig;
        len_cnt_d    = len_cnt_q;
        gap_cnt_d    = gap_cnt_q;
`ifdef DDS_CHIRP_CTRL_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
        tmo_fail_d   = tmo_fail_q;
        err_d        = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                // ACK must be low first so a handshake cut short by reset has fully closed.
                if (pend_q && !ACK) begin
                    launch       = 1'b1;
                    cfg_loaded_d = 1'b0;
                    state_d      = StSetup;
                end else if (trig && cfg_loaded_q && (cfg_act_q.len != '0)) begin
                    trig_drop_d = 1'b0;
                    len_cnt_d   = cfg_act_q.len - LenW'(1);
                    state_d     = StChirp;
                end
            end
            StSetup: begin
`ifdef DDS_CHIRP_CTRL_TIMEOUT_EN
                tmo_cnt_d  = '0;
                tmo_fail_d = 1'b0;
`endif
                state_d = StXferReq;
            end
            StXferReq: begin
                if (ACK) begin
                    state_d = StXferRel;
`ifdef DDS_CHIRP_CTRL_TIMEOUT_EN
                end else if (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
                    tmo_fail_d = 1'b1;
                    err_d      = 1'b1;
                    state_d    = StXferRel;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TmoW'(1);
`endif
                end
            end
            StXferRel: begin
                if (!ACK) begin
                    cfg_loaded_d = !xfer_fail;
                    state_d      = StIdle;
                end
            end
            StChirp: begin
                if (len_cnt_q == '0) begin
                    gap_cnt_d = GapW'(GAP_CYCLES - 1);
                    state_d   = StGap;
                end else begin
                    len_cnt_d = len_cnt_q - LenW'(1);
                end
            end
            StGap: begin
                if (gap_cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q - GapW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
        // REQ and start are registered decodes of the next state: glitch-free across the CDC.
        req_d   = (state_d == StXferReq);
        start_d = (state_d == StChirp);
    end

    always_ff @(posedge clk_48 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cfg_pend_q   <= '0;
            cfg_act_q    <= '0;
            pend_q       <= 1'b0;
            req_q        <= 1'b0;
            start_q      <= 1'b0;
            cfg_loaded_q <= 1'b0;
            trig_drop_q  <= 1'b0;
            len_cnt_q    <= '0;
            gap_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            start_q      <= start_d;
            cfg_loaded_q <= cfg_loaded_d;
            trig_drop_q  <= trig_drop_d;
            len_cnt_q    <= len_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            // A write in the launch cycle re-arms pend with the newer value.
            if (cfg_wr) begin
                cfg_pend_q <= '{freq: cfg_freq, delta_freq: cfg_delta_freq,
                                delta_rate: cfg_delta_rate, len: cfg_len};
                pend_q     <= 1'b1;
            end else if (launch) begin
                pend_q <= 1'b0;
            end
            if (launch) begin
                cfg_act_q <= cfg_pend_q;
            end
        end
    end

`ifdef DDS_CHIRP_CTRL_TIMEOUT_EN
    always_ff @(posedge clk_48 or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q  <= '0;
            tmo_fail_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            tmo_cnt_q  <= tmo_cnt_d;
            tmo_fail_q <= tmo_fail_d;
            err_q      <= err_d;
        end
    end
`endif

    assign REQ            = req_q;
    assign start          = start_q;
    assign busy           = (state_q != StIdle);
    assign cfg_loaded     = cfg_loaded_q;
    assign trig_drop      = trig_drop_q;
    assign DDS_freq       = cfg_act_q.freq;
    assign DDS_delta_freq = cfg_act_q.delta_freq;
    assign DDS_delta_rate = cfg_act_q.delta_rate;

endmodule

// File: tb/tb_dds_chirp_ctrl.sv
// tb_dds_chirp_ctrl: directed self-checking bench for dds_chirp_ctrl.
// Expected configurations are queued when cfg_wr is driven (last-write-wins model of the
// pending register) and popped when REQ rises; expected chirp lengths are queued on trig
// and popped when the start pulse ends.
module tb_dds_chirp_ctrl;
    import dds_chirp_pkg::*;

    logic        clk_48 = 1'b0;
    logic        rst_n;
    logic        cfg_wr;
    logic [47:0] cfg_freq;
    logic [47:0] cfg_delta_freq;
    logic [31:0] cfg_delta_rate;
    logic [31:0] cfg_len;
    logic        trig;
    logic        REQ;
    logic        ACK;
    logic [47:0] DDS_freq;
    logic [47:0] DDS_delta_freq;
    logic [31:0] DDS_delta_rate;
    logic        start;
    logic        busy;
    logic        cfg_loaded;
    logic        trig_drop;
    logic        err_timeout;

    dds_chirp_ctrl #(
        .GAP_CYCLES    (4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_48        (clk_48),
        .rst_n         (rst_n),
        .cfg_wr        (cfg_wr),
        .cfg_freq      (cfg_freq),
        .cfg_delta_freq(cfg_delta_freq),
        .cfg_delta_rate(cfg_delta_rate),
        .cfg_len       (cfg_len),
        .trig          (trig),
        .REQ           (REQ),
        .ACK           (ACK),
        .DDS_freq      (DDS_freq),
        .DDS_delta_freq(DDS_delta_freq),
        .DDS_delta_rate(DDS_delta_rate),
        .start         (start),
        .busy          (busy),
        .cfg_loaded    (cfg_loaded),
        .trig_drop     (trig_drop),
        .err_timeout   (err_timeout)
    );

    always #10 clk_48 = ~clk_48;

    int             n_checks = 0;
    int             n_err    = 0;
    dds_chirp_cfg_t exp_q[$];
    int             len_q[$];
    bit             pend_valid = 0;
    dds_chirp_cfg_t last;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_48);
        #1;
    endtask

    task automatic cfg_drive(input logic [47:0] f, input logic [47:0] df,
                             input logic [31:0] dr, input logic [31:0] ln);
        dds_chirp_cfg_t c;
        cfg_freq       = f;
        cfg_delta_freq = df;
        cfg_delta_rate = dr;
        cfg_len        = ln;
        cfg_wr         = 1'b1;
        c.freq = f; c.delta_freq = df; c.delta_rate = dr; c.len = ln;
        if (pend_valid && exp_q.size() > 0) void'(exp_q.pop_back());
        exp_q.push_back(c);
        pend_valid = 1;
    endtask

    task automatic cfg_write(input logic [47:0] f, input logic [47:0] df,
                             input logic [31:0] dr, input logic [31:0] ln);
        cfg_drive(f, df, dr, ln);
        tick();
        cfg_wr = 1'b0;
    endtask

    // Waits (bounded) for REQ, then compares the bundled data with the next expected config.
    task automatic wait_req(input int exp_ticks, input string tag);
        int n = 0;
        while (REQ !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_req_seen"}, REQ, 1);
        if (exp_ticks >= 0) check({tag, "_req_latency"}, n, exp_ticks);
        last = '0;
        if (exp_q.size() > 0) last = exp_q.pop_front();
        pend_valid = 0;
        check({tag, "_freq"}, DDS_freq, last.freq);
        check({tag, "_delta_freq"}, DDS_delta_freq, last.delta_freq);
        check({tag, "_delta_rate"}, DDS_delta_rate, last.delta_rate);
    endtask

    // Receiver side: ACK 6 cycles after REQ rise, held 3 cycles, then released.
    task automatic ack_cycle(input string tag);
        bit bad = 0;
        repeat (5) begin
            tick();
            if (REQ !== 1'b1 || DDS_freq !== last.freq) bad = 1;
        end
        check({tag, "_req_held"}, bad, 0);
        ACK = 1'b1;
        tick();
        check({tag, "_req_drop"}, REQ, 0);
        tick();
        tick();
        check({tag, "_loaded_wait"}, {busy, cfg_loaded}, 2'b10);
        check({tag, "_freq_frozen"}, DDS_freq, last.freq);
        ACK = 1'b0;
        tick();
        check({tag, "_loaded"}, {busy, cfg_loaded}, 2'b01);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  width;
        int  exp_len;
        bit  moved;
        bit  dropped;
        bit  bad;

        rst_n = 1'b0; cfg_wr = 1'b0; trig = 1'b0; ACK = 1'b0;
        cfg_freq = '0; cfg_delta_freq = '0; cfg_delta_rate = '0; cfg_len = '0;
        #1;
        check("reset_outputs", {REQ, start, busy, cfg_loaded, trig_drop, err_timeout}, 0);
        check("reset_dds", DDS_freq, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // trig with no configuration loaded is dropped for exactly one cycle.
        trig = 1'b1; tick(); trig = 1'b0;
        check("noload_drop", {trig_drop, start, busy}, 3'b100);
        tick();
        check("noload_drop_pulse", trig_drop, 0);

        // First transfer: REQ exactly 3 cycles after cfg_wr.
        cfg_write(48'h0000_2800_0000, 48'h0000_0000_0100, 32'd7, 32'd100);
        check("a_pend_no_req", REQ, 0);
        wait_req(2, "a");
        ack_cycle("a");

        // Chirp of 100 cycles with a trig and a cfg_wr inside the window.
        len_q.push_back(100);
        trig = 1'b1; tick(); trig = 1'b0;
        width = 0; moved = 0; dropped = 0;
        while (start === 1'b1 && width < 300) begin
            if (DDS_freq !== last.freq) moved = 1;
            if (width == 10) trig = 1'b1;
            if (width == 20) cfg_drive(48'h0000_3000_0000, 48'h0000_0000_0200, 32'd9, 32'd5);
            width++;
            tick();
            trig = 1'b0;
            cfg_wr = 1'b0;
            if (trig_drop === 1'b1) dropped = 1;
        end
        exp_len = len_q.pop_front();
        check("chirp_width", width, exp_len);
        check("chirp_trig_drop", dropped, 1);
        check("chirp_no_retune", moved, 0);
        bad = 0;
        repeat (3) begin
            tick();
            if (start !== 1'b0 || busy !== 1'b1 || REQ !== 1'b0 || DDS_freq !== last.freq)
                bad = 1;
        end
        check("gap_hold", bad, 0);
        tick();
        check("gap_end_idle", {busy, start}, 2'b00);
        check("gap_end_freq", DDS_freq, last.freq);
        wait_req(2, "c");
        ack_cycle("c");
        check("no_second_chirp", start, 0);

        // pend and trig together in IDLE: transfer wins, trig dropped.
        cfg_write(48'h0000_1111_0000, 48'h0000_0000_0011, 32'd3, 32'd8);
        trig = 1'b1; tick(); trig = 1'b0;
        check("pend_trig", {trig_drop, busy, start}, 3'b110);
        wait_req(1, "d");

        // Two writes during one handshake: only the second follows.
        cfg_write(48'h0000_2222_0000, 48'h0000_0000_0022, 32'd4, 32'd9);
        cfg_write(48'h0000_3333_0000, 48'h0000_0000_0033, 32'd5, 32'd0);
        ack_cycle("d");
        wait_req(2, "f");
        ack_cycle("f");

        // cfg_len of zero: trig is dropped, no chirp.
        trig = 1'b1; tick(); trig = 1'b0;
        check("len0_drop", {trig_drop, start, busy}, 3'b100);

        // Asynchronous reset mid-handshake with ACK lingering high.
        cfg_write(48'h0000_4444_0000, 48'h0000_0000_0044, 32'd6, 32'd10);
        wait_req(2, "r");
        #2;
        ACK = 1'b1;
        rst_n = 1'b0;
        #1;
        check("rst_async_outputs", {REQ, start, busy, cfg_loaded, trig_drop, err_timeout}, 0);
        check("rst_async_dds", {DDS_freq, DDS_delta_rate[15:0]}, 0);
        tick();
        rst_n = 1'b1;
        pend_valid = 0;
        cfg_write(48'h0000_5555_0000, 48'h0000_0000_0055, 32'd2, 32'd4);
        bad = 0;
        repeat (2) begin
            tick();
            if (REQ !== 1'b0 || busy !== 1'b0) bad = 1;
        end
        check("rst_ack_high_blocks", bad, 0);
        ACK = 1'b0;
        wait_req(2, "s");
        ack_cycle("s");

`ifdef DDS_CHIRP_CTRL_TIMEOUT_EN
        // Timeout: ACK never answers.
        cfg_write(48'h0000_6666_0000, 48'h0000_0000_0066, 32'd1, 32'd3);
        wait_req(2, "t");
        width = 1;
        tick();
        while (REQ === 1'b1 && width < 100) begin
            width++;
            tick();
        end
        check("tmo_req_width", width, 16);
        check("tmo_err", err_timeout, 1);
        repeat (4) tick();
        check("tmo_final", {err_timeout, cfg_loaded, busy, REQ}, 4'b1000);
`else
        check("no_tmo_err", err_timeout, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
